// File: rtl/seq_multiplier_if.sv
// ----------------------------------------------------------------------------
// seq_multiplier_if
//   Start/ready handshake and result bus of the sequential multiplier.
//
//   Signals:
//     start   - request to begin a multiply (master -> slave)
//     A, B    - WIDTH-bit unsigned operands   (master -> slave)
//     ready   - slave is idle and will accept start (slave -> master)
//     done    - one-cycle pulse, Product newly valid (slave -> master)
//     Product - 2*WIDTH-bit registered result        (slave -> master)
//
//   Modports:
//     master - the requester that issues operands
//     slave  - the multiplier itself
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

interface seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 ready;
  logic                 done;
  logic [2*WIDTH-1:0]   Product;

  modport master (
    output start, A, B,
    input  ready, done, Product
  );

  modport slave (
    input  start, A, B,
    output ready, done, Product
  );
endinterface

// File: rtl/seq_multiplier.sv
// ----------------------------------------------------------------------------
// seq_multiplier
//   Unsigned shift-and-add multiplier. Operands are captured on the edge where
//   start is seen while idle; the product is produced exactly WIDTH iterations
//   later and held on Product until the next completion.
//
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-high reset
//     bus   - seq_multiplier_if.slave (start, A, B, ready, done, Product)
//
//   Datapath: accumulator register fed by a 2*WIDTH-bit adder; a 2:1 mux
//   picks either the adder output or the held accumulator on each iteration,
//   steered by the current LSB of the shifting multiplier.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  seq_multiplier_if.slave   bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q,  mplr_d;
  logic [PW-1:0]    acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [PW-1:0]    product_q, product_d;

  // Adder: carry-in 0; no carry-out is kept because a WIDTH x WIDTH product
  // always fits in 2*WIDTH bits.
  logic [PW-1:0] sum;
  assign sum = acc_q + mcand_q;

  // 2:1 mux: add when the current multiplier bit is set, otherwise hold.
  logic [PW-1:0] acc_next;
  assign acc_next = mplr_q[0] ? sum : acc_q;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = {{WIDTH{1'b0}}, bus.A};
          mplr_d  = bus.B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        acc_d   = acc_next;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        // The final iteration's sum goes straight to Product, so partial
        // sums never appear on the output.
        if (cnt_q == CNT_LAST) begin
          product_d = acc_next;
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Handshake flags decode straight from the state register, which makes
  // ready and done mutually exclusive by construction.
  assign bus.ready   = (state_q == IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.Product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// ----------------------------------------------------------------------------
// tb_seq_multiplier
//   Directed bench for seq_multiplier with WIDTH=8. Drives the handshake
//   through the interface master side and compares every output against
//   hand-computed values.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_seq_multiplier;

  localparam int WIDTH = 8;
  localparam int PW    = 2 * WIDTH;

  logic clk;
  logic reset;

  int checks   = 0;
  int failures = 0;

  logic [PW-1:0] prev_product;

  seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation starting with ready=1, at posedge+1.
  task automatic do_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [PW-1:0] expected, input string tag);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    step();  // edge 0: accepted
    bus.start = 1'b0;
    bus.A     = 8'hA5;  // operands may change freely once accepted
    bus.B     = 8'h5A;
    check({tag, " ready after accept"}, 32'(bus.ready), 32'd0);
    for (int k = 1; k < WIDTH; k++) begin
      step();
      check($sformatf("%s done busy k=%0d", tag, k), 32'(bus.done), 32'd0);
      check($sformatf("%s hold busy k=%0d", tag, k), 32'(bus.Product),
            32'(prev_product));
    end
    step();  // edge WIDTH
    check({tag, " done pulse"}, 32'(bus.done), 32'd1);
    check({tag, " ready in done"}, 32'(bus.ready), 32'd0);
    check({tag, " product"}, 32'(bus.Product), 32'(expected));
    step();  // edge WIDTH+1
    check({tag, " done cleared"}, 32'(bus.done), 32'd0);
    check({tag, " ready back"}, 32'(bus.ready), 32'd1);
    check({tag, " product held"}, 32'(bus.Product), 32'(expected));
    prev_product = expected;
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    prev_product = '0;

    #12;
    check("reset ready", 32'(bus.ready), 32'd1);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset product", 32'(bus.Product), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Basic vectors
    do_mul(8'd13,  8'd11,  16'h008F, "13x11");
    do_mul(8'd255, 8'd255, 16'hFE01, "255x255");
    do_mul(8'd0,   8'd200, 16'h0000, "0x200");
    do_mul(8'd1,   8'd1,   16'h0001, "1x1");

    // start activity during BUSY must not disturb the operation in flight
    bus.start = 1'b1;
    bus.A     = 8'd6;
    bus.B     = 8'd7;
    step();  // edge 0
    bus.A = 8'd9;
    bus.B = 8'd9;
    for (int k = 1; k < WIDTH; k++) begin
      if (k == 4) bus.start = 1'b0;
      step();
      check($sformatf("intf done busy k=%0d", k), 32'(bus.done), 32'd0);
    end
    step();  // edge 8
    check("intf done pulse", 32'(bus.done), 32'd1);
    check("intf product", 32'(bus.Product), 32'd42);
    step();
    check("intf ready back", 32'(bus.ready), 32'd1);
    check("intf done cleared", 32'(bus.done), 32'd0);
    step();
    check("intf no second done", 32'(bus.done), 32'd0);
    check("intf idle ready", 32'(bus.ready), 32'd1);
    prev_product = 16'd42;

    // start held high: back-to-back operations every WIDTH+2 cycles
    bus.start = 1'b1;
    bus.A     = 8'd3;
    bus.B     = 8'd5;
    step();  // edge 0 of first accept
    for (int k = 1; k < 30; k++) begin
      step();
      check($sformatf("b2b done k=%0d", k), 32'(bus.done),
            (k % 10 == 8) ? 32'd1 : 32'd0);
      check($sformatf("b2b ready k=%0d", k), 32'(bus.ready),
            (k % 10 == 9) ? 32'd1 : 32'd0);
      check($sformatf("b2b product k=%0d", k), 32'(bus.Product),
            (k < 8) ? 32'd42 : 32'd15);
    end
    bus.start = 1'b0;
    step();
    check("b2b stop ready", 32'(bus.ready), 32'd1);
    check("b2b stop product", 32'(bus.Product), 32'd15);
    prev_product = 16'd15;

    // Asynchronous reset in the middle of an operation
    bus.start = 1'b1;
    bus.A     = 8'd200;
    bus.B     = 8'd100;
    step();  // edge 0
    bus.start = 1'b0;
    for (int k = 1; k < 4; k++) step();
    #2;
    reset = 1'b1;
    #1;
    check("abort ready", 32'(bus.ready), 32'd1);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort product", 32'(bus.Product), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("abort hold done k=%0d", k), 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    check("post reset ready", 32'(bus.ready), 32'd1);
    check("post reset done", 32'(bus.done), 32'd0);
    prev_product = '0;

    do_mul(8'd20, 8'd10, 16'd200, "20x10");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
